// File: rtl/sp_pkg.sv
// Shared types and constants for the processor/APB subsystem blocks.
// Holds the instruction word type, opcode field bounds and loader states.
package sp_pkg;

  typedef logic [31:0] instr_t;

  localparam int unsigned OPC_MSB            = 31;
  localparam int unsigned OPC_LSB            = 29;
  localparam logic [2:0]  OPC_IMEM_WR        = 3'b011;
  localparam int unsigned DEFAULT_IMEM_DEPTH = 64;

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_WR0  = 3'd1,
    S_WR1  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Loads instruction pairs into CPU instruction memory, then runs the CPU
// until it reports done or the watchdog aborts the run.
module imem_loader
  import sp_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_IMEM_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  instr_t        ld_instr0,
  input  instr_t        ld_instr1,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output instr_t        imem_wdata,
  output logic          run,
  input  logic          cpudone,
  input  logic          wdt_trigger_reset,
  output logic          done,
  output logic [AW-1:0] pair_count,
  output logic          err_full,
  output logic          err_abort
);

  localparam int unsigned PW      = AW + 1;
  localparam logic [PW-1:0] PTR_END = PW'(DEPTH);

  loader_state_e state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic [AW-1:0] count_d;
  instr_t        instr0_q, instr0_d, instr1_q, instr1_d;
  logic          last_q, last_d;
  logic          err_full_d, err_abort_d;
  logic          handshake;

  logic          ready_d, we_d, run_d, done_d;
  logic [AW-1:0] waddr_d;
  instr_t        wdata_d;

  assign handshake = ld_valid & ld_ready;
  assign ptr_inc   = ptr_q + PW'(2);

  // Next-state, datapath and next-cycle output values; outputs are registered
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = pair_count;
    instr0_d    = instr0_q;
    instr1_d    = instr1_q;
    last_d      = last_q;
    err_full_d  = err_full;
    err_abort_d = err_abort;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    run_d       = 1'b0;
    done_d      = 1'b0;
    waddr_d     = imem_waddr;
    wdata_d     = imem_wdata;

    unique case (state_q)
      S_LOAD: begin
        if (handshake) begin
          instr0_d = ld_instr0;
          instr1_d = ld_instr1;
          last_d   = ld_last;
          // A zero first word is a filler pair: nothing is written or counted
          if (ld_instr0 == '0) begin
            if (ld_last) state_d = S_RUN;
          end else begin
            state_d = S_WR0;
          end
        end
      end
      S_WR0: state_d = S_WR1;
      S_WR1: begin
        ptr_d   = ptr_inc;
        count_d = pair_count + AW'(1);
        if (last_q) begin
          state_d = S_RUN;
        end else if (ptr_inc == PTR_END) begin
          err_full_d = 1'b1;
          state_d    = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (wdt_trigger_reset) begin
          err_abort_d = 1'b1;
          ptr_d       = '0;
          count_d     = '0;
          state_d     = S_LOAD;
        end else if (cpudone) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = '0;
        count_d = '0;
        state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    ready_d = (state_d == S_LOAD) && (ptr_d < PTR_END);
    run_d   = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    if (state_d == S_WR0) begin
      we_d    = 1'b1;
      waddr_d = ptr_d[AW-1:0];
      wdata_d = instr0_d;
    end else if (state_d == S_WR1) begin
      we_d    = 1'b1;
      waddr_d = AW'(ptr_d + PW'(1));
      wdata_d = instr1_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_LOAD;
      ptr_q      <= '0;
      instr0_q   <= '0;
      instr1_q   <= '0;
      last_q     <= 1'b0;
      pair_count <= '0;
      err_full   <= 1'b0;
      err_abort  <= 1'b0;
      ld_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      run        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      last_q     <= last_d;
      pair_count <= count_d;
      err_full   <= err_full_d;
      err_abort  <= err_abort_d;
      ld_ready   <= ready_d;
      imem_we    <= we_d;
      imem_waddr <= waddr_d;
      imem_wdata <= wdata_d;
      run        <= run_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a program-level model predicts the
// write stream, its timing, run/done behaviour and the sticky error flags.
module tb_imem_loader;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [31:0]   ld_instr0, ld_instr1;
  logic          ld_last;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          run;
  logic          cpudone;
  logic          wdt;
  logic          done;
  logic [AW-1:0] pair_count;
  logic          err_full, err_abort;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_instr0(ld_instr0), .ld_instr1(ld_instr1),
    .ld_last(ld_last), .ld_ready(ld_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .run(run), .cpudone(cpudone), .wdt_trigger_reset(wdt), .done(done),
    .pair_count(pair_count), .err_full(err_full), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] i0; logic [31:0] i1; bit last; } pair_t;
  typedef struct { int cyc; int addr; logic [31:0] data; } wr_t;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    exp_err_full = 0;
  bit    exp_err_abort = 0;
  pair_t prog[$];
  wr_t   wr_log[$];
  wr_t   wr_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed memory write, stamped with the cycle it is visible in
  always @(negedge clk)
    if (imem_we === 1'b1) wr_log.push_back('{cyc, int'(imem_waddr), imem_wdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_nz();
    logic [31:0] v = $urandom;
    if (v == 0) v = 32'h1;
    return v;
  endfunction

  function automatic pair_t rand_pair();
    pair_t p;
    p.i0   = ($urandom_range(0, 3) == 0) ? 32'h0 : rand_nz();
    p.i1   = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'($urandom);
    p.last = 1'b0;
    return p;
  endfunction

  task automatic send_pair(input logic [31:0] i0, input logic [31:0] i1,
                           input bit last, output int hs);
    int n = 0;
    ld_valid = 1'b1; ld_instr0 = i0; ld_instr1 = i1; ld_last = last;
    while (ld_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("hs_wait_expired", 64'(n >= 40), 64'(0));
    hs = cyc;
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    ld_instr0 = $urandom; ld_instr1 = $urandom;
  endtask

  // Sends prog until the model says the program ends, then checks writes and run state
  task automatic run_program();
    int  ptr = 0;
    int  pc = 0;
    int  hs = 0;
    int  prev_hs = -1;
    int  prev_gap = 0;
    int  run_at = -1;
    bit  full = 0;
    wr_log.delete();
    wr_exp.delete();
    foreach (prog[k]) begin
      if (run_at >= 0) break;
      send_pair(prog[k].i0, prog[k].i1, prog[k].last, hs);
      if (prev_hs >= 0) check("hs_spacing", 64'(hs - prev_hs), 64'(prev_gap));
      check("ready_after_hs", 64'(ld_ready), 64'(prog[k].i0 == 0 && !prog[k].last));
      check("we_after_hs", 64'(imem_we), 64'(prog[k].i0 != 0));
      if (prog[k].i0 != 0) begin
        wr_exp.push_back('{hs + 1, ptr, prog[k].i0});
        wr_exp.push_back('{hs + 2, ptr + 1, prog[k].i1});
        ptr += 2;
        pc++;
        if (prog[k].last || ptr == int'(DEPTH)) run_at = hs + 3;
        if (!prog[k].last && ptr == int'(DEPTH)) full = 1;
        prev_gap = 3;
      end else begin
        if (prog[k].last) run_at = hs + 1;
        prev_gap = 1;
      end
      prev_hs = hs;
    end
    if (run_at < 0) run_at = cyc;
    while (run !== 1'b1 && cyc < run_at + 8) @(negedge clk);
    check("run_rise_cycle", 64'(cyc), 64'(run_at));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    exp_err_full |= full;
    check("write_count", 64'(wr_log.size()), 64'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_log.size(); i++) begin
      check("write_addr", 64'(wr_log[i].addr), 64'(wr_exp[i].addr));
      check("write_data", 64'(wr_log[i].data), 64'(wr_exp[i].data));
      check("write_cycle", 64'(wr_log[i].cyc), 64'(wr_exp[i].cyc));
    end
    check("run_held", 64'(run), 64'(1));
    check("ready_in_run", 64'(ld_ready), 64'(0));
    check("pair_count", 64'(pair_count), 64'(pc));
    check("err_full", 64'(err_full), 64'(exp_err_full));
    check("err_abort_hold", 64'(err_abort), 64'(exp_err_abort));
  endtask

  // mode 0: cpudone, 1: watchdog, 2: watchdog and cpudone together
  task automatic end_program(input int mode);
    cpudone = (mode != 1);
    wdt     = (mode != 0);
    @(negedge clk);
    cpudone = 1'b0;
    wdt     = 1'b0;
    if (mode != 0) exp_err_abort = 1;
    check("done_pulse", 64'(done), 64'(mode == 0));
    check("run_fall", 64'(run), 64'(0));
    check("err_abort", 64'(err_abort), 64'(exp_err_abort));
    if (mode == 0) begin
      check("ready_in_done", 64'(ld_ready), 64'(0));
      @(negedge clk);
      check("done_width", 64'(done), 64'(0));
    end
    check("ready_reload", 64'(ld_ready), 64'(1));
    check("count_cleared", 64'(pair_count), 64'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(ld_ready), 64'(1));
    check({tag, "_we"}, 64'(imem_we), 64'(0));
    check({tag, "_waddr"}, 64'(imem_waddr), 64'(0));
    check({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
    check({tag, "_run"}, 64'(run), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_count"}, 64'(pair_count), 64'(0));
    check({tag, "_errs"}, 64'({err_full, err_abort}), 64'(0));
  endtask

  initial begin
    int hs;
    reset = 1'b1; ld_valid = 1'b0; ld_instr0 = '0; ld_instr1 = '0; ld_last = 1'b0;
    cpudone = 1'b0; wdt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("post_rst");

    // Three-pair program from the bring-up sequence
    prog.delete();
    prog.push_back('{32'h6000_0001, 32'h1234_5678, 1'b0});
    prog.push_back('{32'h2000_0002, 32'h0, 1'b0});
    prog.push_back('{32'h4000_0003, 32'h0, 1'b1});
    run_program();
    end_program(0);

    // Filler pair, then a real last pair that must land at address 0
    prog.delete();
    prog.push_back('{32'h0, 32'hDEAD_BEEF, 1'b0});
    prog.push_back('{32'h6000_0010, 32'h5, 1'b1});
    run_program();
    end_program(0);

    // Empty program still runs
    prog.delete();
    prog.push_back('{32'h0, 32'h0, 1'b1});
    run_program();
    end_program(0);

    // Fill memory without last, abort with watchdog and cpudone together
    prog.delete();
    for (int k = 0; k < 4; k++) prog.push_back('{rand_nz(), 32'($urandom), 1'b0});
    run_program();
    end_program(2);

    // Watchdog and cpudone outside a run are ignored
    wdt = 1'b1; cpudone = 1'b1;
    @(negedge clk);
    wdt = 1'b0; cpudone = 1'b0;
    check("idle_wdt_abort", 64'(err_abort), 64'(exp_err_abort));
    check("idle_done", 64'(done), 64'(0));
    check("idle_ready", 64'(ld_ready), 64'(1));
    check("idle_run", 64'(run), 64'(0));

    // Reset while the first word is being written drops the second write
    send_pair(32'h6000_0020, 32'hCAFE_F00D, 1'b1, hs);
    check("wr0_we", 64'(imem_we), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err_full = 0;
    exp_err_abort = 0;
    check_reset_state("rst_wr0");

    for (int t = 0; t < 30; t++) begin
      bit nolast = ($urandom_range(0, 4) == 0);
      int n = $urandom_range(1, 6);
      prog.delete();
      for (int k = 0; k < n; k++) prog.push_back(rand_pair());
      if (nolast) begin
        for (int k = 0; k < 4; k++) prog.push_back('{rand_nz(), 32'($urandom), 1'b0});
      end else begin
        prog[prog.size() - 1].last = 1'b1;
      end
      run_program();
      end_program($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware instruction loader that sits directly upstream of the CPU instruction memory in the processor/APB peripheral subsystem. Accepts instruction pairs from a stimulus or host source over a valid/ready handshake and writes them sequentially into instruction memory through a single write port. Once the program is complete, it asserts `run`, holds it until the CPU reports `cpudone`, then returns to loading. It replaces hierarchical backdoor writes into `dut.cpu1.imemory.mem`.

## Interface
- `DEPTH`, 64: instruction memory words; must be even and ≥ 2.
- `AW`, `$clog2(DEPTH)`: `imem_waddr` width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_valid` in 1: instruction pair offered.
- `ld_instr0` in 32: first word, `{opcode[31:29], addr, data}`.
- `ld_instr1` in 32: second word (companion or 0).
- `ld_last` in 1: this pair ends the program.
- `ld_ready` out 1: loader can accept a pair.
- `imem_we` out 1: instruction memory write strobe.
- `imem_waddr` out AW: write address.
- `imem_wdata` out 32: write data.
- `run` out 1: CPU run enable.
- `cpudone` in 1: CPU finished program.
- `wdt_trigger_reset` in 1: watchdog abort.
- `done` out 1: one-cycle pulse when the CPU completes.
- `pair_count` out AW: pairs written in the current program.
- `err_full` out 1: sticky; memory filled before `ld_last`.
- `err_abort` out 1: sticky; run aborted by watchdog.

## Operation
- FSM states: `S_LOAD`, `S_WR0`, `S_WR1`, `S_RUN`, `S_DONE`.
- `S_LOAD`:
  - `ld_ready=1` when `ptr<DEPTH`.
  - A handshake (`ld_valid & ld_ready`) latches `instr0`, `instr1`, and `last`.
  - If `ld_instr0==0`, the pair is dropped: no write, no count. If `last` is also set, go to `S_RUN`; otherwise stay in `S_LOAD`. An empty program still runs.
  - Otherwise go to `S_WR0`.
- `S_WR0`: write `instr0` at `ptr`, then go to `S_WR1`.
- `S_WR1`:
  - Write `instr1` at `ptr+1`, even if it is 0.
  - Update `ptr+=2`, `pair_count+=1`.
  - If `last_q`, go to `S_RUN`.
  - Else if the new `ptr==DEPTH`, set `err_full` and go to `S_RUN`.
  - Else go to `S_LOAD`.
- `ptr` is AW+1 bits wide and never wraps; writes never exceed `DEPTH-1`.
- `S_RUN`:
  - `run=1`.
  - On `cpudone`, go to `S_DONE`.
  - On `wdt_trigger_reset` (which has priority over `cpudone` in the same cycle), set `err_abort`, force `run=0`, clear `ptr` and `pair_count`, and go to `S_LOAD`. No `done` pulse.
- `S_DONE`: `done=1`, `run=0`, clear `ptr` and `pair_count`, then go to `S_LOAD`.
- `wdt_trigger_reset` outside `S_RUN` is ignored.
- Sticky errors clear only on `reset`.
- `reset` in any state:
  - Next state is `S_LOAD`.
  - `ptr`, `pair_count`, `err_full`, and `err_abort` cleared to 0.
  - A write pending in `S_WR0`/`S_WR1` is discarded (`imem_we=0`).

## Timing
- Reset values:
  - `ld_ready=1` (in the first cycle after reset).
  - `imem_we=0`, `imem_waddr=0`, `imem_wdata=0`.
  - `run=0`, `done=0`, `pair_count=0`, `err_full=0`, `err_abort=0`.
- All outputs are registered or decoded from state. No combinational path from `ld_valid` to `ld_ready`.
- Write sequence for a handshake in cycle N:
  - Cycle N+1: `instr0` written.
  - Cycle N+2: `instr1` written.
  - Cycle N+3: `ld_ready` high again, or `run` high if last/full.
- Throughput: one pair per 3 cycles.
- `ld_ready=0` in `S_WR0`, `S_WR1`, `S_RUN`, and `S_DONE`. Sources must hold data until the handshake.
- `cpudone` seen in cycle M: `done` pulses in M+1, `run` is 0 in M+1, `ld_ready` is 1 in M+2.
- Dropped-pair handshake: `ld_ready` remains 1 the following cycle.

## Structure
- Shared package `sp_pkg`:
  - `typedef logic [31:0] instr_t`
  - `OPC_MSB=31`, `OPC_LSB=29`
  - `OPC_IMEM_WR=3'b011`
  - `loader_state_e` enum
  - `DEFAULT_IMEM_DEPTH=64`
- Single module with no sub-module. FSM, pointer, and error flags all live in `imem_loader`.
- The CPU instruction memory gains a write port (`we`, `waddr`, `wdata`) driven by this block.

## Test plan
- Reset, then 3 pairs `{0x6000_0001,0x1234_5678}`, `{0x2000_0002,0}`, `{0x4000_0003,0}` with `last` on the third → imem[0..5] holds exactly those words, `pair_count=3`, `run` rises 3 cycles after the last handshake.
- `DEPTH=8`, 4 pairs without `last` → writes to addresses 0..7, `err_full=1`, `run=1`, `ld_ready=0`, no write at address 8.
- Pair with `ld_instr0=0`, `ld_last=0` → no `imem_we`, `pair_count` unchanged, `ld_ready=1` on the next cycle.
- In `S_RUN`, pulse `cpudone` → `done` is high for exactly 1 cycle, `run` falls, and a new program loads at address 0.
- In `S_RUN`, assert `wdt_trigger_reset` and `cpudone` in the same cycle → `err_abort=1`, `done` stays 0, `run` falls the next cycle.
- Assert `reset` in `S_WR0` → no write in the following cycle, all outputs at reset values, `ld_ready=1`.
